mem_access_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit_sat.sv | 17 +
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM state encoding and address-range helper for the
// memory-stage controller and its testbench.
package mem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Unsigned compare over the full address width
  function automatic logic addrInRange(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the execute stage (master) and
// the memory-stage controller (slave).
interface mem_access_unit_if;
  import mem_pkg::*;

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqData;
  logic [2:0]        ReqTag;
  logic              RespValid;
  logic              RespReady;
  logic [DATA_W-1:0] RespData;
  logic [2:0]        RespTag;
  logic              RespFault;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqData, ReqTag, RespReady,
    input  ReqReady, RespValid, RespData, RespTag, RespFault
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, ReqTag, RespReady,
    output ReqReady, RespValid, RespData, RespTag, RespFault
  );

endinterface

// File: rtl/mem_access_unit_sat.sv
// 8-bit saturating event counter with synchronous clear; sticks at 255.
module sat_counter8 (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge Clock) begin
    if (Clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load/store per handshake, drives the memory
// strobes, captures registered read data and returns a tagged response.
module mem_access_unit #(
  parameter int DATA_W    = mem_pkg::DATA_W,
  parameter int ADDR_W    = mem_pkg::ADDR_W,
  parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH
) (
  input  logic              Clock,
  input  logic              Clear,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemData,
  output logic [7:0]        FaultCount
);
  import mem_pkg::*;

  state_t            state;
  logic              latWrite;
  logic              reqReady;
  logic              respValid;
  logic              respFault;
  logic [DATA_W-1:0] respData;
  logic [2:0]        respTag;
  logic              reqFault;
  logic              faultInc;

  assign reqFault = !addrInRange(bus.ReqAddr);
  assign faultInc = (state == ST_IDLE) && bus.ReqValid && reqFault;

  assign bus.ReqReady  = reqReady;
  assign bus.RespValid = respValid;
  assign bus.RespFault = respFault;
  assign bus.RespData  = respData;
  assign bus.RespTag   = respTag;

  // Every output is a register updated here; the memory only sees strobes
  // for exactly one cycle in ACCESS, and read data is grabbed in CAPTURE
  // because the memory zeroes its output one edge later.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state        <= ST_IDLE;
      latWrite     <= 1'b0;
      reqReady     <= 1'b1;
      respValid    <= 1'b0;
      respFault    <= 1'b0;
      respData     <= '0;
      respTag      <= '0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ReqValid) begin
            latWrite <= bus.ReqWrite;
            respTag  <= bus.ReqTag;
            reqReady <= 1'b0;
            if (reqFault) begin
              state     <= ST_RESP;
              respValid <= 1'b1;
              respFault <= 1'b1;
              respData  <= '0;
            end else begin
              state        <= ST_ACCESS;
              respFault    <= 1'b0;
              MemAddr      <= bus.ReqAddr;
              MemWriteData <= bus.ReqData;
              MemWrite     <= bus.ReqWrite;
              MemRead      <= !bus.ReqWrite;
            end
          end
        end
        ST_ACCESS: begin
          MemWrite <= 1'b0;
          MemRead  <= 1'b0;
          if (latWrite) begin
            state     <= ST_RESP;
            respValid <= 1'b1;
            respData  <= '0;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          respData  <= MemData;
          respValid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.RespReady) begin
            respValid <= 1'b0;
            reqReady  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter8 faultCounter (
    .Clock (Clock),
    .Clear (Clear),
    .inc   (faultInc),
    .count (FaultCount)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// registered-output data memory preloaded so that word x holds x.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic              Clock = 1'b0;
  logic              Clear = 1'b1;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] MemData;
  logic [7:0]        FaultCount;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .Clock        (Clock),
    .Clear        (Clear),
    .bus          (bus.slave),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemData      (MemData),
    .FaultCount   (FaultCount)
  );

  always #5 Clock = ~Clock;

  logic [DATA_W-1:0] memArray [MEM_DEPTH];
  int errors = 0;
  int checks = 0;
  int strobeCount = 0;
  int overlapCount = 0;

  // Clear reloads the x = x pattern; output is zero unless a read strobe was seen
  always @(posedge Clock) begin
    if (Clear) begin
      MemData <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) memArray[i] <= DATA_W'(i);
    end else begin
      if (MemWrite && (MemAddr < ADDR_W'(MEM_DEPTH))) memArray[MemAddr[3:0]] <= MemWriteData;
      if (MemRead && (MemAddr < ADDR_W'(MEM_DEPTH))) MemData <= memArray[MemAddr[3:0]];
      else MemData <= '0;
    end
  end

  always @(negedge Clock) begin
    if (MemRead || MemWrite) strobeCount++;
    if (MemRead && MemWrite) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Issue one request at a negedge; returns at the negedge after acceptance
  task automatic applyStimulus(input logic write, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic [2:0] tag);
    int guard = 0;
    while (!bus.ReqReady && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    checkOutput("reqReadyBeforeAccept", 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1;
    bus.ReqWrite = write;
    bus.ReqAddr  = addr;
    bus.ReqData  = data;
    bus.ReqTag   = tag;
    @(posedge Clock);
    @(negedge Clock);
    bus.ReqValid = 1'b0;
  endtask

  task automatic waitResponse(output int latency);
    latency = 1;
    while (!bus.RespValid && latency < 20) begin
      @(negedge Clock);
      latency++;
    end
    if (!bus.RespValid) checkOutput("respTimeout", 32'd0, 32'd1);
  endtask

  task automatic finishResponse();
    bus.RespReady = 1'b1;
    @(negedge Clock);
    bus.RespReady = 1'b0;
    checkOutput("respValidAfterHandshake", 32'(bus.RespValid), 32'd0);
    checkOutput("reqReadyAfterHandshake", 32'(bus.ReqReady), 32'd1);
  endtask

  initial begin
    int lat;
    int snap;
    int bad;
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = 1'b0;
    bus.ReqAddr   = '0;
    bus.ReqData   = '0;
    bus.ReqTag    = '0;
    bus.RespReady = 1'b0;

    repeat (2) @(negedge Clock);
    Clear = 1'b0;
    checkOutput("rstReqReady", 32'(bus.ReqReady), 32'd1);
    checkOutput("rstRespValid", 32'(bus.RespValid), 32'd0);
    checkOutput("rstRespFault", 32'(bus.RespFault), 32'd0);
    checkOutput("rstRespData", 32'(bus.RespData), 32'd0);
    checkOutput("rstRespTag", 32'(bus.RespTag), 32'd0);
    checkOutput("rstStrobes", 32'({MemRead, MemWrite}), 32'd0);
    checkOutput("rstMemAddr", 32'(MemAddr), 32'd0);
    checkOutput("rstMemWriteData", 32'(MemWriteData), 32'd0);
    checkOutput("rstFaultCount", 32'(FaultCount), 32'd0);

    applyStimulus(1'b0, 16'd3, 16'd0, 3'd5);
    waitResponse(lat);
    checkOutput("load3Latency", 32'(lat), 32'd3);
    checkOutput("load3Data", 32'(bus.RespData), 32'd3);
    checkOutput("load3Tag", 32'(bus.RespTag), 32'd5);
    checkOutput("load3Fault", 32'(bus.RespFault), 32'd0);
    finishResponse();

    applyStimulus(1'b1, 16'd5, 16'd256, 3'd2);
    waitResponse(lat);
    checkOutput("store5Latency", 32'(lat), 32'd2);
    checkOutput("store5Data", 32'(bus.RespData), 32'd0);
    checkOutput("store5Tag", 32'(bus.RespTag), 32'd2);
    checkOutput("store5Fault", 32'(bus.RespFault), 32'd0);
    finishResponse();
    applyStimulus(1'b0, 16'd5, 16'd0, 3'd3);
    waitResponse(lat);
    checkOutput("load5Latency", 32'(lat), 32'd3);
    checkOutput("load5Data", 32'(bus.RespData), 32'd256);
    checkOutput("load5Tag", 32'(bus.RespTag), 32'd3);
    finishResponse();

    snap = strobeCount;
    applyStimulus(1'b0, 16'd9, 16'd0, 3'd1);
    waitResponse(lat);
    checkOutput("fault9Latency", 32'(lat), 32'd1);
    checkOutput("fault9Fault", 32'(bus.RespFault), 32'd1);
    checkOutput("fault9Data", 32'(bus.RespData), 32'd0);
    checkOutput("fault9Tag", 32'(bus.RespTag), 32'd1);
    finishResponse();
    applyStimulus(1'b0, 16'hFFFF, 16'd0, 3'd6);
    waitResponse(lat);
    checkOutput("faultFFFFFault", 32'(bus.RespFault), 32'd1);
    checkOutput("faultFFFFData", 32'(bus.RespData), 32'd0);
    finishResponse();
    checkOutput("faultNoStrobes", 32'(strobeCount - snap), 32'd0);
    checkOutput("faultCountTwo", 32'(FaultCount), 32'd2);

    applyStimulus(1'b0, 16'd7, 16'd0, 3'd4);
    waitResponse(lat);
    checkOutput("load7Latency", 32'(lat), 32'd3);
    snap = strobeCount;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      checkOutput("holdRespValid", 32'(bus.RespValid), 32'd1);
      checkOutput("holdRespData", 32'(bus.RespData), 32'd7);
      checkOutput("holdRespTag", 32'(bus.RespTag), 32'd4);
      checkOutput("holdReqReady", 32'(bus.ReqReady), 32'd0);
    end
    checkOutput("holdNoStrobes", 32'(strobeCount - snap), 32'd0);
    finishResponse();

    applyStimulus(1'b0, 16'd2, 16'd0, 3'd7);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    checkOutput("clrReqReady", 32'(bus.ReqReady), 32'd1);
    checkOutput("clrRespValid", 32'(bus.RespValid), 32'd0);
    checkOutput("clrFaultCount", 32'(FaultCount), 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (bus.RespValid) bad++;
    end
    checkOutput("clrNoStaleResp", 32'(bad), 32'd0);

    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1'b0, 16'd100 + 16'(i), 16'd0, 3'(i));
      if (!(bus.RespValid && bus.RespFault)) bad++;
      finishResponse();
      if (i == 200) checkOutput("satCount200", 32'(FaultCount), 32'd200);
      if (i == 255) checkOutput("satCount255", 32'(FaultCount), 32'd255);
    end
    checkOutput("satFaultFlags", 32'(bad), 32'd0);
    checkOutput("satCountHeld", 32'(FaultCount), 32'd255);
    applyStimulus(1'b0, 16'd9, 16'd0, 3'd3);
    checkOutput("satLaterFault", 32'(bus.RespFault), 32'd1);
    finishResponse();
    checkOutput("satCountFinal", 32'(FaultCount), 32'd255);

    applyStimulus(1'b0, 16'd8, 16'd0, 3'd0);
    waitResponse(lat);
    checkOutput("load8Data", 32'(bus.RespData), 32'd8);
    finishResponse();

    checkOutput("strobeOverlap", 32'(overlapCount), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
